// File: rtl/nids_pkg.sv
// Shared encodings for the NIDS decision stage: class ids, FSM states, Q6.10 constants.
package nids_pkg;

    localparam int NUM_CLASSES = 4;
    localparam int FRAC_BITS   = 10;

    localparam logic [1:0] CLS_DOS      = 2'd0;
    localparam logic [1:0] CLS_PORTSCAN = 2'd1;
    localparam logic [1:0] CLS_DDOS     = 2'd2;
    localparam logic [1:0] CLS_PATATOR  = 2'd3;

    localparam logic signed [15:0] DEFAULT_THRESHOLD = 16'sh0800;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

endpackage

// File: rtl/attack_event_counters.sv
// Per-class saturating counters of accepted alerts; built only with NIDS_ATTACK_CNT_EN.
module attack_event_counters
    import nids_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    input  logic [1:0]           inc_cls,
    input  logic [1:0]           cnt_sel,
    output logic [CNT_WIDTH-1:0] cnt_value
);

    logic [NUM_CLASSES-1:0][CNT_WIDTH-1:0] cnt;

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt[g] <= '0;
            else if (clr)
                cnt[g] <= '0;
            else if (inc && inc_cls == 2'(g) && cnt[g] != '1)
                cnt[g] <= cnt[g] + 1'b1;
        end
    end

    assign cnt_value = cnt[cnt_sel];

endmodule

// File: rtl/nids_decision_unit.sv
// Sequential argmax over four class scores, threshold + persistence filter, valid/ready alert.
// Optional per-class alert counters are enabled by defining NIDS_ATTACK_CNT_EN.
module nids_decision_unit
    import nids_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PERSIST    = 2
`ifdef NIDS_ATTACK_CNT_EN
   ,parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         cls_done,
    input  logic signed [DATA_WIDTH-1:0] dos_score,
    input  logic signed [DATA_WIDTH-1:0] portscan_score,
    input  logic signed [DATA_WIDTH-1:0] ddos_score,
    input  logic signed [DATA_WIDTH-1:0] patator_score,
    input  logic signed [DATA_WIDTH-1:0] threshold,
`ifdef NIDS_ATTACK_CNT_EN
    input  logic [1:0]                   cnt_sel,
    output logic [CNT_WIDTH-1:0]         cnt_value,
`endif
    output logic                         alert_valid,
    input  logic                         alert_ready,
    output logic [1:0]                   alert_class,
    output logic signed [DATA_WIDTH-1:0] alert_score,
    output logic                         benign,
    output logic                         busy,
    output logic                         dropped
);

    localparam int PW = $clog2(PERSIST + 1);

    state_t state, state_nxt;

    logic                         cls_done_q;
    logic                         rise;
    logic                         accept;
    logic signed [DATA_WIDTH-1:0] score_q [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] best_score;
    logic [1:0]                   best_idx;
    logic [1:0]                   scan_idx;
    logic [1:0]                   prev_cls;
    logic [PW-1:0]                persist_cnt;
    logic [PW-1:0]                persist_nxt;
    logic                         flagged;

    assign rise   = cls_done & ~cls_done_q;
    assign accept = alert_valid & alert_ready;
    assign busy   = (state != ST_IDLE);

    always_comb begin
        flagged     = (best_score > threshold);
        persist_nxt = '0;
        if (flagged) begin
            if (best_idx != prev_cls)
                persist_nxt = PW'(1);
            else if (persist_cnt == PW'(PERSIST))
                persist_nxt = persist_cnt;
            else
                persist_nxt = persist_cnt + 1'b1;
        end

        state_nxt = state;
        case (state)
            ST_IDLE:   if (rise) state_nxt = ST_SCAN;
            ST_SCAN:   if (scan_idx == CLS_PATATOR) state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = (persist_nxt == PW'(PERSIST)) ? ST_EMIT : ST_IDLE;
            ST_EMIT:   if (accept) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (clr)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_done_q  <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++)
                score_q[i] <= '0;
            best_score  <= '0;
            best_idx    <= CLS_DOS;
            scan_idx    <= CLS_DOS;
            prev_cls    <= CLS_DOS;
            persist_cnt <= '0;
            alert_valid <= 1'b0;
            alert_class <= CLS_DOS;
            alert_score <= '0;
            benign      <= 1'b0;
            dropped     <= 1'b0;
        end else if (clr) begin
            cls_done_q  <= 1'b0;
            prev_cls    <= CLS_DOS;
            persist_cnt <= '0;
            alert_valid <= 1'b0;
            alert_class <= CLS_DOS;
            alert_score <= '0;
            benign      <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            cls_done_q <= cls_done;
            dropped    <= rise && (state != ST_IDLE);
            case (state)
                ST_IDLE: if (rise) begin
                    score_q[0] <= dos_score;
                    score_q[1] <= portscan_score;
                    score_q[2] <= ddos_score;
                    score_q[3] <= patator_score;
                    best_score <= dos_score;
                    best_idx   <= CLS_DOS;
                    scan_idx   <= CLS_PORTSCAN;
                end
                ST_SCAN: begin
                    // strict compare keeps the lower index on ties
                    if (score_q[scan_idx] > best_score) begin
                        best_score <= score_q[scan_idx];
                        best_idx   <= scan_idx;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                ST_DECIDE: begin
                    persist_cnt <= persist_nxt;
                    benign      <= ~flagged;
                    if (flagged)
                        prev_cls <= best_idx;
                    if (persist_nxt == PW'(PERSIST)) begin
                        alert_valid <= 1'b1;
                        alert_class <= best_idx;
                        alert_score <= best_score;
                    end
                end
                ST_EMIT: if (accept) begin
                    alert_valid <= 1'b0;
                    persist_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef NIDS_ATTACK_CNT_EN
    attack_event_counters #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .inc       (accept),
        .inc_cls   (alert_class),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value)
    );
`endif

endmodule

// File: tb/tb_nids_decision_unit.sv
// Directed bench for nids_decision_unit: table of windows plus hand-written handshake/reset sequences.
module tb_nids_decision_unit;
    import nids_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clr = 1'b0;
    logic               cls_done = 1'b0;
    logic signed [15:0] dos_score = '0, portscan_score = '0, ddos_score = '0, patator_score = '0;
    logic signed [15:0] threshold = DEFAULT_THRESHOLD;
    logic               alert_valid;
    logic               alert_ready = 1'b0;
    logic [1:0]         alert_class;
    logic signed [15:0] alert_score;
    logic               benign, busy, dropped;
`ifdef NIDS_ATTACK_CNT_EN
    logic [1:0]         cnt_sel = 2'd0;
    logic [15:0]        cnt_value;
`endif

    nids_decision_unit dut (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr),
        .cls_done       (cls_done),
        .dos_score      (dos_score),
        .portscan_score (portscan_score),
        .ddos_score     (ddos_score),
        .patator_score  (patator_score),
        .threshold      (threshold),
`ifdef NIDS_ATTACK_CNT_EN
        .cnt_sel        (cnt_sel),
        .cnt_value      (cnt_value),
`endif
        .alert_valid    (alert_valid),
        .alert_ready    (alert_ready),
        .alert_class    (alert_class),
        .alert_score    (alert_score),
        .benign         (benign),
        .busy           (busy),
        .dropped        (dropped)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [15:0] Q4 = 16'(4 << FRAC_BITS);  // 4.0 = 0x1000

    typedef struct packed {
        logic [15:0] d, p, dd, pa, thr;
        logic        v;
        logic [1:0]  cls;
        logic [15:0] sc;
        logic        ben;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input logic [15:0] d, p, dd, pa, thr);
        threshold      = thr;
        dos_score      = d;
        portscan_score = p;
        ddos_score     = dd;
        patator_score  = pa;
        cls_done       = 1'b1;
        tick();
        cls_done       = 1'b0;
    endtask

    task automatic run_window(input logic [15:0] d, p, dd, pa, thr);
        start_window(d, p, dd, pa, thr);
        repeat (4) tick();
    endtask

    task automatic accept_alert(input string name);
        alert_ready = 1'b1;
        tick();
        alert_ready = 1'b0;
        chk({name, "_deassert"}, alert_valid, 0);
    endtask

    initial begin
        logic stable;

        // Windows run in order; persistence state carries across rows.
        vt[0]  = '{16'h0400, 16'h0C00, 16'h0A00, 16'h0200, 16'h0800, 1'b0, 2'd0, 16'h0000, 1'b0};
        vt[1]  = '{16'h0400, 16'h0C00, 16'h0A00, 16'h0200, 16'h0800, 1'b1, 2'd1, 16'h0C00, 1'b0};
        vt[2]  = '{16'h0800, 16'h0800, 16'h0100, 16'h0700, 16'h0800, 1'b0, 2'd0, 16'h0000, 1'b1};
        vt[3]  = '{16'h0400, 16'h0C00, 16'h0A00, 16'h0200, 16'h0800, 1'b0, 2'd0, 16'h0000, 1'b0};
        vt[4]  = '{Q4,       Q4,       16'h0000, 16'h0000, 16'h0800, 1'b0, 2'd0, 16'h0000, 1'b0};
        vt[5]  = '{Q4,       Q4,       16'h0000, 16'h0000, 16'h0800, 1'b1, 2'd0, 16'h1000, 1'b0};
        vt[6]  = '{16'h0000, 16'h0000, 16'h0C00, 16'h0000, 16'h0800, 1'b0, 2'd0, 16'h0000, 1'b0};
        vt[7]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0C00, 16'h0800, 1'b0, 2'd0, 16'h0000, 1'b0};
        vt[8]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0C00, 16'h0800, 1'b1, 2'd3, 16'h0C00, 1'b0};
        vt[9]  = '{16'h8000, 16'hFC00, 16'hF000, 16'h0100, 16'hF800, 1'b0, 2'd0, 16'h0000, 1'b0};
        vt[10] = '{16'h8000, 16'hFC00, 16'hF000, 16'h0100, 16'hF800, 1'b1, 2'd3, 16'h0100, 1'b0};
        vt[11] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 2'd0, 16'h0000, 1'b1};
        vt[12] = '{16'hF000, 16'hFC00, 16'hF000, 16'hF000, 16'hF800, 1'b0, 2'd0, 16'h0000, 1'b0};

        // reset state
        #12;
        chk("rst_valid", alert_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_benign", benign, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            run_window(vt[i].d, vt[i].p, vt[i].dd, vt[i].pa, vt[i].thr);
            chk($sformatf("vec%0d_valid", i), alert_valid, vt[i].v);
            chk($sformatf("vec%0d_benign", i), benign, vt[i].ben);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].v);
            chk($sformatf("vec%0d_dropped", i), dropped, 0);
            if (vt[i].v) begin
                chk($sformatf("vec%0d_class", i), alert_class, vt[i].cls);
                chk($sformatf("vec%0d_score", i), alert_score, vt[i].sc);
                accept_alert($sformatf("vec%0d", i));
            end
        end

        // held alert under backpressure, drop during EMIT, back-to-back capture
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_benign", benign, 0);
        run_window(16'h0400, 16'h0C00, 16'h0A00, 16'h0200, 16'h0800);
        run_window(16'h0400, 16'h0C00, 16'h0A00, 16'h0200, 16'h0800);
        chk("hold_valid", alert_valid, 1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) cls_done = 1'b1;
            if (i == 5) cls_done = 1'b0;
            tick();
            if (i == 3) chk("drop_pulse", dropped, 1);
            if (i == 4) chk("drop_one_cycle", dropped, 0);
            stable &= (alert_valid === 1'b1) && (alert_class === 2'd1) && (alert_score === 16'sh0C00);
        end
        chk("hold_stable", stable, 1);
        chk("hold_busy", busy, 1);
        accept_alert("hold");
        start_window(16'h0400, 16'h0C00, 16'h0A00, 16'h0200, 16'h0800);
        chk("b2b_captured", busy, 1);
        chk("b2b_no_drop", dropped, 0);
        repeat (4) tick();
        chk("b2b_valid", alert_valid, 0);
        chk("b2b_benign", benign, 0);

        // async reset mid-SCAN
        run_window(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0800);
        chk("pre_rst_benign", benign, 1);
        start_window(16'h0000, 16'h0C00, 16'h0000, 16'h0000, 16'h0800);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_scan_busy", busy, 0);
        chk("rst_scan_benign", benign, 0);
        chk("rst_scan_class", alert_class, 0);
        chk("rst_scan_score", alert_score, 0);
        chk("rst_scan_valid", alert_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // latency of the alerting window, then clr while in EMIT
        run_window(16'h0000, 16'h0000, 16'h0C00, 16'h0000, 16'h0800);
        start_window(16'h0000, 16'h0000, 16'h0C00, 16'h0000, 16'h0800);
        repeat (3) tick();
        chk("lat_c4_valid", alert_valid, 0);
        chk("lat_c4_busy", busy, 1);
        tick();
        chk("lat_c5_valid", alert_valid, 1);
        chk("lat_c5_class", alert_class, 2);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_emit_valid", alert_valid, 0);
        chk("clr_emit_busy", busy, 0);
        chk("clr_emit_class", alert_class, 0);

`ifdef NIDS_ATTACK_CNT_EN
        for (int k = 0; k < 2; k++) begin
            run_window(16'h0000, 16'h0000, 16'h0C00, 16'h0000, 16'h0800);
            run_window(16'h0000, 16'h0000, 16'h0C00, 16'h0000, 16'h0800);
            chk("cnt_alert_valid", alert_valid, 1);
            accept_alert("cnt_alert");
        end
        cnt_sel = 2'd2; #1;
        chk("cnt_ddos", cnt_value, 2);
        cnt_sel = 2'd0; #1;
        chk("cnt_dos", cnt_value, 0);
        cnt_sel = 2'd2;
        clr = 1'b1; tick(); clr = 1'b0;
        chk("cnt_clr", cnt_value, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nids_decision_unit.md
# nids_decision_unit

Post-classifier decision stage of the NIDS pipeline. It consumes the four softplus attack scores (DoS, PortScan, DDoS, Patator) and the classifier's completion pulse, then selects the highest-scoring class by sequential argmax and compares it against a programmable threshold. An alert is raised only after the same class is flagged in `PERSIST` consecutive windows; the alert is delivered over a valid/ready handshake to the host/alert logic.

## Interface
- `DATA_WIDTH`, 16, score/threshold width, signed Q6.10
- `PERSIST`, 2, consecutive flagged windows of the same class required to alert (≥1)
- `CNT_WIDTH`, 16, width of per-class alert counters (macro only)

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `clr` in 1 — synchronous clear of all state
- `cls_done` in 1 — classifier completion; a window is captured on its rising edge
- `dos_score`, `portscan_score`, `ddos_score`, `patator_score` in `DATA_WIDTH` signed — class scores, valid while `cls_done` is high
- `threshold` in `DATA_WIDTH` signed — quasi-static detection threshold
- `alert_valid` out 1 — alert pending
- `alert_ready` in 1 — consumer accepts the alert
- `alert_class` out 2 — 0 DoS, 1 PortScan, 2 DDoS, 3 Patator
- `alert_score` out `DATA_WIDTH` signed — winning score
- `benign` out 1 — last decided window had no score above threshold
- `busy` out 1 — FSM not in IDLE
- `dropped` out 1 — one-cycle pulse when a window arrives and cannot be captured
- `cnt_sel` in 2, `cnt_value` out `CNT_WIDTH` — present only with `NIDS_ATTACK_CNT_EN`

## Operation
- FSM states: IDLE, SCAN, DECIDE, EMIT.
- IDLE: on a `cls_done` rising edge (`cls_done` high and previous-cycle registered copy low), latch all four scores, set best = DoS (idx 0), and go to SCAN.
- SCAN: 3 cycles comparing indices 1, 2, 3 in order. A candidate replaces best only if strictly greater (signed). Ties therefore resolve to the lower index.
- DECIDE, 1 cycle, three cases:
  - best > `threshold` (strict) and best class equals the previous flagged class: persist count increments, saturating at `PERSIST`.
  - best > `threshold` and the class differs: persist count = 1, previous class = best class.
  - Otherwise: persist count = 0 and `benign` = 1.
  - `benign` is cleared in either flagged case.
  - If the count reaches `PERSIST`, load `alert_class`/`alert_score` and go to EMIT; else go to IDLE.
- EMIT: `alert_valid` is held high with stable class and score until `alert_valid && alert_ready`.
  - On acceptance: deassert next cycle, persist count = 0, go to IDLE.
- A `cls_done` rising edge in any state other than IDLE is ignored and pulses `dropped`.
- `clr` (sync) returns to IDLE and zeroes the persist count, previous class, outputs and edge register. With the macro, `clr` also zeroes the counters. `clr` has priority over all other events.
- `rst`: all registers and outputs go to 0 (`alert_valid`, `alert_class`, `alert_score`, `benign`, `busy`, `dropped`, counters). An in-flight window is discarded.

## Timing
- Rising edge sampled at cycle 0 → SCAN cycles 1–3 → DECIDE cycle 4 → `alert_valid`/`benign` update visible at cycle 5.
- Minimum window spacing for no drop is 5 cycles without alert. With an alert, spacing is 5 cycles plus the handshake wait.
- `busy` is high from cycle 1 until the cycle after IDLE is re-entered.
- Back-to-back: acceptance at cycle N → IDLE at N+1, and a rising edge at N+1 is captured.

## Configuration
- `NIDS_ATTACK_CNT_EN`, when defined:
  - Four `CNT_WIDTH` saturating counters, one per class.
  - A counter increments on each accepted alert handshake of its class.
  - `cnt_value` = counter[`cnt_sel`], combinational.
- When undefined, `cnt_sel`, `cnt_value` and the counters do not exist. All other behaviour is identical.

## Structure
- Shared package `nids_pkg`:
  - Class encoding constants (DOS=0, PORTSCAN=1, DDOS=2, PATATOR=3).
  - FSM state encoding.
  - `FRAC_BITS`=10.
  - Default threshold 16'sh0800 (2.0).
- Sub-module `attack_event_counters` holds the macro-gated counter bank. It is instantiated only under `NIDS_ATTACK_CNT_EN`.

## Test plan
- Threshold 0x0800, `PERSIST`=2; scores 0x0400/0x0C00/0x0A00/0x0200 in two windows → window 1: no alert, `benign`=0; window 2: `alert_valid` at cycle 5, class 1, score 0x0C00.
- All scores ≤ 0x0800 (max exactly 0x0800) → `benign`=1 at cycle 5, no alert, persist reset (next flagged window alone does not alert).
- DoS = PortScan = 0x1000, others 0, two windows → alert class 0.
- `alert_ready` held low 10 cycles, new `cls_done` edge during EMIT → `dropped` 1-cycle pulse; alert outputs stable. Raise ready → `alert_valid` low next cycle.
- Window 1 DDoS max 0x0C00, window 2 Patator max 0x0C00 → no alert; window 3 Patator → alert class 3.
- `rst` asserted during SCAN → all outputs 0 immediately. With the macro: two accepted DDoS alerts → `cnt_sel`=2 reads 2; `clr` → 0.
